ysyx_25050147_ifu: RTL and testbench

Instruction fetch unit for the ysyx_25050147 single-issue core, sitting directly upstream of the decode stage. It owns the architectural PC and issues one word read at a time to instruction memory over a valid/ready request channel. Each returned 32-bit word is registered and presented to decode with its PC under a valid/ready handshake. Redirects from execute/writeback replace the sequential PC and cancel any fetch in flight.

---
 rtl/ysyx_25050147_ifu.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_25050147_ifu.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25050147_ifu.sv
// Instruction fetch unit for the ysyx_25050147 core.
// It owns the PC, issues one instruction-memory read at a time and holds
// one returned instruction for decode. Redirects replace the PC and cancel
// any fetch in flight.
// Optional macro YSYX_25050147_IFU_ALIGN_CHECK_EN: a misaligned redirect
// target is not fetched. Instead a faulting nop is presented at that PC.
module ysyx_25050147_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_fault,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  // IDLE is only reachable after a faulting instruction is consumed.
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, IDLE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] addr_reg, addr_next;
  logic        kill_reg, kill_next;
  logic [31:0] inst_reg, inst_next;
  logic [31:0] inst_pc_reg, inst_pc_next;

  logic [31:0] target;     // redirect target as it is loaded into pc
  logic        target_mis; // redirect target is misaligned (checked builds)
  logic        pc_mis;     // pc holds a misaligned target awaiting its fault
  logic        held_fault; // the held instruction is a fault
  logic        fault_go;
  logic [31:0] fault_pc;

`ifdef YSYX_25050147_IFU_ALIGN_CHECK_EN
  logic inst_fault_reg, inst_fault_next;
  assign target     = redirect_pc;
  assign target_mis = redirect_pc[1:0] != 2'b00;
  assign pc_mis     = pc_reg[1:0] != 2'b00;
  assign held_fault = inst_fault_reg;
  assign inst_fault = inst_fault_reg;
`else
  assign target     = redirect_pc & ~32'h3;
  assign target_mis = 1'b0;
  assign pc_mis     = 1'b0;
  assign held_fault = 1'b0;
  assign inst_fault = 1'b0;
`endif

  assign imem_req_valid = rst_n && (state_reg == FETCH);
  assign imem_addr      = addr_reg;
  assign inst_valid     = (state_reg == HOLD);
  assign inst           = inst_reg;
  assign inst_pc        = inst_pc_reg;

  // Next-state logic: redirect takes priority over the normal flow.
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    addr_next    = addr_reg;
    kill_next    = kill_reg;
    inst_next    = inst_reg;
    inst_pc_next = inst_pc_reg;
    fault_go     = 1'b0;
    fault_pc     = target;
    case (state_reg)
      FETCH: begin
        if (imem_req_ready) state_next = WAIT;
        // The presented request is committed; its response gets discarded.
        if (redirect_valid) begin
          pc_next   = target;
          kill_next = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid) begin
            kill_next = 1'b0;
            pc_next   = target;
            if (target_mis) begin
              fault_go = 1'b1;
            end else begin
              addr_next  = target;
              state_next = FETCH;
            end
          end else if (kill_reg) begin
            kill_next = 1'b0;
            if (pc_mis) begin
              fault_go = 1'b1;
              fault_pc = pc_reg;
            end else begin
              addr_next  = pc_reg;
              state_next = FETCH;
            end
          end else begin
            inst_next    = imem_resp_data;
            inst_pc_next = addr_reg;
            state_next   = HOLD;
          end
        end else if (redirect_valid) begin
          pc_next   = target;
          kill_next = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_next = target;
          if (target_mis) begin
            fault_go = 1'b1;
          end else begin
            addr_next  = target;
            state_next = FETCH;
          end
        end else if (inst_ready) begin
          if (held_fault) begin
            state_next = IDLE;
          end else begin
            pc_next    = pc_reg + 32'd4;
            addr_next  = pc_reg + 32'd4;
            state_next = FETCH;
          end
        end
      end
      default: begin
        if (redirect_valid) begin
          pc_next = target;
          if (target_mis) begin
            fault_go = 1'b1;
          end else begin
            addr_next  = target;
            state_next = FETCH;
          end
        end
      end
    endcase
    if (fault_go) begin
      inst_next    = NOP;
      inst_pc_next = fault_pc;
      state_next   = HOLD;
    end
  end

`ifdef YSYX_25050147_IFU_ALIGN_CHECK_EN
  // Fault flag follows whatever was loaded into the holding registers.
  always_comb begin
    inst_fault_next = inst_fault_reg;
    if (fault_go) inst_fault_next = 1'b1;
    else if (state_reg == WAIT && state_next == HOLD) inst_fault_next = 1'b0;
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inst_fault_reg <= 1'b0;
    else        inst_fault_reg <= inst_fault_next;
  end
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= FETCH;
      pc_reg      <= RESET_PC;
      addr_reg    <= RESET_PC;
      kill_reg    <= 1'b0;
      inst_reg    <= 32'h0;
      inst_pc_reg <= 32'h0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      addr_reg    <= addr_next;
      kill_reg    <= kill_next;
      inst_reg    <= inst_next;
      inst_pc_reg <= inst_pc_next;
    end
  end

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// Directed testbench for ysyx_25050147_ifu with hand-computed expectations.
module tb_ysyx_25050147_ifu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int compared = 0;
  int mismatched = 0;

  ysyx_25050147_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .inst_fault(inst_fault), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_addr", imem_addr, 32'h8000_0000);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fault", {31'b0, inst_fault}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    $display("txn: reset released");
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_addr, 32'h8000_0000);

    // Basic fetch, L=1
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093;
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    chk("wait_no_valid", {31'b0, inst_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    chk("f1_valid", {31'b0, inst_valid}, 32'd1);
    chk("f1_inst", inst, 32'h0010_0093);
    chk("f1_pc", inst_pc, 32'h8000_0000);
    chk("f1_fault", {31'b0, inst_fault}, 32'd0);
    $display("txn: fetch pc=%h inst=%h", inst_pc, inst);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("f1_next_req", {31'b0, imem_req_valid}, 32'd1);
    chk("f1_next_addr", imem_addr, 32'h8000_0004);
    chk("f1_consumed", {31'b0, inst_valid}, 32'd0);

    // Backpressure for 5 cycles
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113;
    tick();
    imem_resp_valid = 1'b0; imem_resp_data = 32'hdead_beef;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'b0, inst_valid}, 32'd1);
      chk("bp_inst", inst, 32'h0020_0113);
      chk("bp_pc", inst_pc, 32'h8000_0004);
      chk("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
      tick();
    end
    $display("txn: backpressure pc=%h inst=%h", inst_pc, inst);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("bp_next_req", {31'b0, imem_req_valid}, 32'd1);
    chk("bp_next_addr", imem_addr, 32'h8000_0008);

    // Redirect during WAIT, L=3
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("rw_wait_req", {31'b0, imem_req_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b1; imem_resp_data = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0;
    chk("rw_dropped", {31'b0, inst_valid}, 32'd0);
    chk("rw_req", {31'b0, imem_req_valid}, 32'd1);
    chk("rw_addr", imem_addr, 32'h8000_0100);
    $display("txn: redirect in WAIT -> %h", imem_addr);

    // Redirect coincident with HOLD handshake
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193;
    tick();
    imem_resp_valid = 1'b0;
    chk("rh_inst", inst, 32'h0030_0193);
    chk("rh_pc", inst_pc, 32'h8000_0100);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
    tick();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    chk("rh_once", {31'b0, inst_valid}, 32'd0);
    chk("rh_addr", imem_addr, 32'h8000_0200);
    $display("txn: redirect at handshake -> %h", imem_addr);

    // Request stalled 4 cycles, redirect in cycle 2
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin redirect_valid = 1'b1; redirect_pc = 32'h8000_0300; end
      else redirect_valid = 1'b0;
      chk("st_req", {31'b0, imem_req_valid}, 32'd1);
      chk("st_addr", imem_addr, 32'h8000_0200);
      tick();
    end
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    chk("st_addr_acc", imem_addr, 32'h8000_0200);
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h2222_2222;
    tick();
    imem_resp_valid = 1'b0;
    chk("st_dropped", {31'b0, inst_valid}, 32'd0);
    chk("st_addr_new", imem_addr, 32'h8000_0300);
    $display("txn: stalled redirect -> %h", imem_addr);

    // Misaligned redirect coincident with a response in WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h3333_3333;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    tick();
    imem_resp_valid = 1'b0; redirect_valid = 1'b0;
`ifdef YSYX_25050147_IFU_ALIGN_CHECK_EN
    chk("mis_valid", {31'b0, inst_valid}, 32'd1);
    chk("mis_fault", {31'b0, inst_fault}, 32'd1);
    chk("mis_inst", inst, 32'h0000_0013);
    chk("mis_pc", inst_pc, 32'h8000_0102);
    chk("mis_no_req", {31'b0, imem_req_valid}, 32'd0);
    $display("txn: misaligned fault pc=%h", inst_pc);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("mis_idle_req", {31'b0, imem_req_valid}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
`endif
    chk("al_req", {31'b0, imem_req_valid}, 32'd1);
    chk("al_addr", imem_addr, 32'h8000_0100);
    chk("al_valid", {31'b0, inst_valid}, 32'd0);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0213;
    tick();
    imem_resp_valid = 1'b0;
    chk("al_inst", inst, 32'h0040_0213);
    chk("al_pc", inst_pc, 32'h8000_0100);
    chk("al_fault", {31'b0, inst_fault}, 32'd0);
    $display("txn: fetch after redirect pc=%h inst=%h", inst_pc, inst);
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    chk("al_seq_addr", imem_addr, 32'h8000_0104);

    // Reset asserted mid-fetch
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_req", {31'b0, imem_req_valid}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h8000_0000);
    chk("mrst_inst", inst, 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_req", {31'b0, imem_req_valid}, 32'd1);
    $display("txn: reset mid-fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
